dcache_mem_bridge: RTL and testbench
====================================

# dcache_mem_bridge

Memory-side bridge directly downstream of the L1 data cache controller. It accepts one block refill request and one evicted-block writeback from the cache controller, serialises them into 32-bit beats on the main-memory bus, reassembles refill read beats into a full cache block, and returns it as a single-cycle response pulse. Writebacks always drain before a pending refill, so a refill of a just-evicted line returns the written data.

## Interface
- CACHE_BLOCK_SIZE, 128: cache block width in bits; must be a multiple of 32 and at least 64.
- BEATS, CACHE_BLOCK_SIZE/32: derived local parameter, beats per block.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- fill_req_vld_i  in  1  refill request from the cache controller.
- fill_req_addr_i  in  32  refill byte address; the low log2(CACHE_BLOCK_SIZE/8) bits are ignored.
- fill_req_rdy_o  out  1  refill request accepted when vld and rdy are both high.
- fill_resp_vld_o  out  1  one-cycle pulse: refill data is valid.
- fill_resp_data_o  out  CACHE_BLOCK_SIZE  assembled block; beat 0 occupies bits [31:0].
- wb_vld_i  in  1  evicted dirty block offered.
- wb_addr_i  in  32  writeback byte address; low bits are ignored as for refill.
- wb_data_i  in  CACHE_BLOCK_SIZE  evicted block.
- wb_rdy_o  out  1  writeback buffer empty; accepted when vld and rdy are both high.
- mem_req_o  out  1  beat request to main memory.
- mem_we_o  out  1  1 = write beat, 0 = read beat.
- mem_addr_o  out  32  word-aligned beat address.
- mem_wdata_o  out  32  write beat data.
- mem_gnt_i  in  1  memory accepts the current beat this cycle.
- mem_rvalid_i  in  1  read beat returned, in issue order.
- mem_rdata_i  in  32  read beat data.
- busy_o  out  1  any buffer is occupied or the FSM is not in IDLE.

## Operation
- Two single-entry buffers, each with its own valid bit:
  - WB buffer: block-aligned address plus data.
  - Fill buffer: block-aligned address.
- rdy outputs are combinational on buffer emptiness. A buffer whose valid bit is set refuses new input until its transfer completes.
- FSM states: IDLE, WB, RD_ISSUE, RD_WAIT, RESP.
- IDLE:
  - WB buffer valid → WB; else fill buffer valid → RD_ISSUE.
  - Arbitration is evaluated on registered buffer state only; a request accepted this cycle is seen next cycle.
- WB:
  - mem_req_o=1, mem_we_o=1, mem_addr_o=base+4·beat_cnt, mem_wdata_o=block[32·beat_cnt +: 32].
  - beat_cnt increments on mem_gnt_i.
  - On the gnt of beat BEATS-1: clear the WB buffer, reset beat_cnt, go to IDLE.
- RD_ISSUE:
  - mem_req_o=1, mem_we_o=0, addresses as in WB.
  - issue_cnt increments on gnt; on the last gnt → RD_WAIT.
- RD_WAIT (rvalids are also captured during RD_ISSUE):
  - Each mem_rvalid_i writes mem_rdata_i into slot ret_cnt, then ret_cnt increments.
  - When ret_cnt reaches BEATS → RESP.
- RESP: fill_resp_vld_o=1 for exactly one cycle, fill buffer cleared, all counters reset, → IDLE.
- Counters are $clog2(BEATS)+1 bits wide so the value BEATS is representable. Beat address arithmetic is modulo 2^32 with no carry checks.
- mem_rvalid_i with no read outstanding (ret_cnt == issue_cnt) is ignored. An assertion flags it in simulation.
- mem_wdata_o and mem_addr_o are don't-care while mem_req_o=0; they are driven to 0.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - FSM=IDLE; all counters and valid bits 0.
  - All outputs 0 except fill_req_rdy_o=1 and wb_rdy_o=1.
  - Reset mid-transfer discards all in-flight state; late mem_rvalid_i after reset is ignored.
- Accept at edge N → mem_req_o first high in cycle N+1 (IDLE evaluates registered state during N+1 and drives the request combinationally from the next state).
- Refill latency with zero-wait memory (gnt every cycle, rvalid one cycle after gnt):
  - accept N, beats granted N+1..N+BEATS, last rvalid N+BEATS+1, fill_resp_vld_o in cycle N+BEATS+2.
- Ordering:
  - A WB and a fill accepted in the same cycle: the WB completes fully before the first read beat.
  - A WB arriving while a read is in flight waits for RESP.
- mem_req_o, once high, stays high with stable addr, we and data until gnt.

## Structure
- Shared memory package holds CACHE_BLOCK_SIZE, the block offset bit count, and the bridge_state_e enum; the cache controller imports the same package.
- Single module with no sub-modules. The two buffers are plain registers, not FIFOs.

## Test plan
- Refill, BEATS=4: fill addr 0x0000_1234 → read beats at 0x1230, 0x1234, 0x1238, 0x123C; rdata 0xA0..0xA3 → fill_resp_data_o = {A3,A2,A1,A0}, one-cycle pulse at accept+6.
- Writeback: addr 0x2000, data {D3,D2,D1,D0} → four write beats D0..D3 to 0x2000..0x200C; wb_rdy_o low until the cycle after the last gnt.
- Simultaneous WB (0x3000) and fill (0x3000) → all 4 write beats precede any read beat; returned block equals the written block (memory model).
- Back-pressure: gnt held low 3 cycles per beat → mem_addr_o, mem_wdata_o and mem_req_o stable throughout; beat order unchanged.
- Reset asserted mid RD_WAIT after 2 of 4 rvalids → outputs at reset values immediately; post-reset fill to 0x4000 returns correct data with no stale slots.
- Second fill offered while one is pending → fill_req_rdy_o stays 0 until the cycle after the RESP pulse.

Source files
------------

// File: rtl/dcache_mem_bridge_pkg.sv
// ============================================================================
// Module   : dcache_mem_bridge_pkg
// Purpose  : Shared memory-side types and block geometry for the L1 D-cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_mem_bridge_pkg;

    localparam int CACHE_BLOCK_SIZE = 128;
    localparam int BLK_OFFSET_BITS  = $clog2(CACHE_BLOCK_SIZE / 8);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WB       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_mem_bridge.sv
// ============================================================================
// Module   : dcache_mem_bridge
// Purpose  : Serialises D-cache refills/writebacks into 32-bit memory beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_mem_bridge
    import dcache_mem_bridge_pkg::*;
#(
    parameter int CACHE_BLOCK_SIZE = dcache_mem_bridge_pkg::CACHE_BLOCK_SIZE
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        fill_req_vld_i,
    input  logic [31:0]                 fill_req_addr_i,
    output logic                        fill_req_rdy_o,
    output logic                        fill_resp_vld_o,
    output logic [CACHE_BLOCK_SIZE-1:0] fill_resp_data_o,
    input  logic                        wb_vld_i,
    input  logic [31:0]                 wb_addr_i,
    input  logic [CACHE_BLOCK_SIZE-1:0] wb_data_i,
    output logic                        wb_rdy_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [31:0]                 mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [31:0]                 mem_rdata_i,
    output logic                        busy_o
);

    localparam int BEATS = CACHE_BLOCK_SIZE / 32;
    localparam int IDX_W = $clog2(BEATS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(CACHE_BLOCK_SIZE / 8);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
    localparam logic [31:0]      BLK_MASK = ~((32'd1 << OFF_W) - 32'd1);

    bridge_state_e state_q, state_d, cur_st;

    logic                  wb_vld_q,   wb_vld_d;
    logic [31:0]           wb_addr_q,  wb_addr_d;
    logic [BEATS-1:0][31:0] wb_data_q, wb_data_d;

    logic                  fill_vld_q,  fill_vld_d;
    logic [31:0]           fill_addr_q, fill_addr_d;
    logic [BEATS-1:0][31:0] fill_data_q, fill_data_d;

    logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q,   ret_cnt_d;

    logic [IDX_W-1:0] beat_idx, issue_idx, ret_idx;

    assign beat_idx  = beat_cnt_q[IDX_W-1:0];
    assign issue_idx = issue_cnt_q[IDX_W-1:0];
    assign ret_idx   = ret_cnt_q[IDX_W-1:0];

    assign fill_req_rdy_o   = ~fill_vld_q;
    assign wb_rdy_o         = ~wb_vld_q;
    assign fill_resp_data_o = fill_data_q;
    assign busy_o           = wb_vld_q | fill_vld_q | (state_q != ST_IDLE);

    always_comb begin
        state_d         = state_q;
        wb_vld_d        = wb_vld_q;
        wb_addr_d       = wb_addr_q;
        wb_data_d       = wb_data_q;
        fill_vld_d      = fill_vld_q;
        fill_addr_d     = fill_addr_q;
        fill_data_d     = fill_data_q;
        beat_cnt_d      = beat_cnt_q;
        issue_cnt_d     = issue_cnt_q;
        ret_cnt_d       = ret_cnt_q;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = 32'd0;
        mem_wdata_o     = 32'd0;
        fill_resp_vld_o = 1'b0;

        // IDLE acts as the first cycle of the chosen transfer so the beat
        // request appears in the cycle right after the buffer fills.
        cur_st = state_q;
        if (state_q == ST_IDLE) begin
            if (wb_vld_q) begin
                cur_st = ST_WB;
            end else if (fill_vld_q) begin
                cur_st = ST_RD_ISSUE;
            end
        end
        state_d = cur_st;

        if (wb_vld_i && !wb_vld_q) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = wb_addr_i & BLK_MASK;
            wb_data_d = wb_data_i;
        end

        if (fill_req_vld_i && !fill_vld_q) begin
            fill_vld_d  = 1'b1;
            fill_addr_d = fill_req_addr_i & BLK_MASK;
        end

        if (mem_rvalid_i && (ret_cnt_q != issue_cnt_q)) begin
            fill_data_d[ret_idx] = mem_rdata_i;
            ret_cnt_d            = ret_cnt_q + 1'b1;
        end

        case (cur_st)
            ST_WB: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = wb_addr_q + 32'({beat_idx, 2'b00});
                mem_wdata_o = wb_data_q[beat_idx];
                if (mem_gnt_i) begin
                    if (beat_cnt_q == CNT_LAST) begin
                        wb_vld_d   = 1'b0;
                        beat_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_RD_ISSUE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = fill_addr_q + 32'({issue_idx, 2'b00});
                if (mem_gnt_i) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == CNT_LAST) begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (ret_cnt_d == CNT_FULL) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                fill_resp_vld_o = 1'b1;
                fill_vld_d      = 1'b0;
                beat_cnt_d      = '0;
                issue_cnt_d     = '0;
                ret_cnt_d       = '0;
                state_d         = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            wb_vld_q    <= 1'b0;
            wb_addr_q   <= 32'd0;
            wb_data_q   <= '0;
            fill_vld_q  <= 1'b0;
            fill_addr_q <= 32'd0;
            fill_data_q <= '0;
            beat_cnt_q  <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wb_vld_q    <= wb_vld_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            fill_vld_q  <= fill_vld_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            beat_cnt_q  <= beat_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    // A read beat with nothing outstanding indicates a memory-side protocol error.
    a_no_spurious_rvalid: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (ret_cnt_q != issue_cnt_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_dcache_mem_bridge.sv
// ============================================================================
// Module   : tb_dcache_mem_bridge
// Purpose  : Directed self-checking bench for dcache_mem_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_mem_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fill_req_vld_i;
    logic [31:0]  fill_req_addr_i;
    logic         fill_req_rdy_o;
    logic         fill_resp_vld_o;
    logic [127:0] fill_resp_data_o;
    logic         wb_vld_i;
    logic [31:0]  wb_addr_i;
    logic [127:0] wb_data_i;
    logic         wb_rdy_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;
    logic         busy_o;

    dcache_mem_bridge #(.CACHE_BLOCK_SIZE(128)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .fill_req_vld_i   (fill_req_vld_i),
        .fill_req_addr_i  (fill_req_addr_i),
        .fill_req_rdy_o   (fill_req_rdy_o),
        .fill_resp_vld_o  (fill_resp_vld_o),
        .fill_resp_data_o (fill_resp_data_o),
        .wb_vld_i         (wb_vld_i),
        .wb_addr_i        (wb_addr_i),
        .wb_data_i        (wb_data_i),
        .wb_rdy_o         (wb_rdy_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int          c;
        logic [31:0] d;
    } rd_t;

    int          total = 0;
    int          bad   = 0;
    int          gnt_wait  = 0;
    int          rv_budget = -1;
    int          rv_count  = 0;
    int          stab_bad  = 0;
    int          cyc       = 0;
    beat_t       log_q[$];
    rd_t         rq[$];
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
        beat_t b;
        b = (i < log_q.size()) ? log_q[i] : '0;
        chk(tag, {63'd0, b.we, b.addr, b.data}, {63'd0, we, a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: grants after gnt_wait stall cycles, returns reads in order.
    initial begin
        int          wait_cnt;
        logic        prev_pend;
        logic        prev_we;
        logic [31:0] prev_addr, prev_wdata, rd;
        wait_cnt  = 0;
        prev_pend = 1'b0;
        prev_we   = 1'b0;
        prev_addr = 32'd0;
        prev_wdata = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'd0;
            if (!rst_n) begin
                rq.delete();
                wait_cnt  = 0;
                prev_pend = 1'b0;
            end else begin
                cyc++;
                if (rv_budget != 0 && rq.size() > 0 && rq[0].c < cyc) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rq[0].d;
                    void'(rq.pop_front());
                    rv_count++;
                    if (rv_budget > 0) rv_budget--;
                end
                if (prev_pend && !(mem_req_o === 1'b1 && mem_we_o === prev_we &&
                                   mem_addr_o === prev_addr && mem_wdata_o === prev_wdata))
                    stab_bad++;
                prev_pend = 1'b0;
                if (mem_req_o === 1'b1) begin
                    if (wait_cnt < gnt_wait) begin
                        wait_cnt++;
                        prev_pend  = 1'b1;
                        prev_we    = mem_we_o;
                        prev_addr  = mem_addr_o;
                        prev_wdata = mem_wdata_o;
                    end else begin
                        mem_gnt_i = 1'b1;
                        wait_cnt  = 0;
                        log_q.push_back('{mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'd0});
                        if (mem_we_o) begin
                            mem[mem_addr_o] = mem_wdata_o;
                        end else begin
                            rd = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'hDEAD_BEEF;
                            rq.push_back('{c: cyc, d: rd});
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int rdy_hi;

        rst_n = 1'b0;
        fill_req_vld_i = 1'b0; fill_req_addr_i = 32'd0;
        wb_vld_i = 1'b0; wb_addr_i = 32'd0; wb_data_i = '0;
        for (int i = 0; i < 4; i++) begin
            mem[32'h1230 + 4*i] = 32'hA0 + i;
            mem[32'h6000 + 4*i] = 32'hB0 + i;
            mem[32'h3000 + 4*i] = 32'hBAD0 + i;
            mem[32'h5000 + 4*i] = 32'h50 + i;
            mem[32'h4000 + 4*i] = 32'hC0 + i;
        end

        // Reset values
        tick(); tick();
        chk("rst_ctrl", {fill_req_rdy_o, wb_rdy_o, mem_req_o, mem_we_o, fill_resp_vld_o, busy_o}, 6'b110000);
        chk("rst_addr", {mem_addr_o, mem_wdata_o}, 64'd0);
        chk("rst_data", fill_resp_data_o, 128'd0);
        rst_n = 1'b1;
        tick();

        // Refill 0x1234, then a second fill held while the first is pending
        log_q.delete();
        fill_req_vld_i = 1'b1; fill_req_addr_i = 32'h0000_1234;
        tick();
        fill_req_addr_i = 32'h0000_6000;
        chk("t1_first_req", {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, 32'h1230});
        n = 1; rdy_hi = 0;
        while (!fill_resp_vld_o && n < 300) begin
            if (fill_req_rdy_o) rdy_hi++;
            tick(); n++;
        end
        if (fill_req_rdy_o) rdy_hi++;
        chk("t1_latency", n, 6);
        chk("t1_data", fill_resp_data_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("t1_rdy_held_low", rdy_hi, 0);
        chk("t1_nbeats", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_beat("t1_beat", i, 1'b0, 32'h1230 + 4*i, 32'd0);
        tick();
        chk("t1_pulse_rdy", {fill_resp_vld_o, fill_req_rdy_o}, 2'b01);
        log_q.delete();
        tick();
        fill_req_vld_i = 1'b0;
        chk("t1b_first_req", {mem_req_o, mem_addr_o}, {1'b1, 32'h6000});
        n = 1;
        while (!fill_resp_vld_o && n < 300) begin tick(); n++; end
        chk("t1b_latency", n, 6);
        chk("t1b_data", fill_resp_data_o, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        tick();

        // Writeback 0x2000 (unaligned offset ignored)
        log_q.delete();
        wb_vld_i = 1'b1; wb_addr_i = 32'h0000_2004;
        wb_data_i = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        tick();
        wb_vld_i = 1'b0;
        chk("t2_first", {wb_rdy_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o},
            {3'b011, 32'h2000, 32'hD0});
        n = 1;
        while (!wb_rdy_o && n < 300) begin tick(); n++; end
        chk("t2_rdy_cycle", n, 5);
        chk("t2_idle", {busy_o, mem_req_o}, 2'b00);
        chk("t2_nbeats", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_beat("t2_beat", i, 1'b1, 32'h2000 + 4*i, 32'hD0 + i);

        // Simultaneous WB and fill to 0x3000: writes drain first, read sees them
        log_q.delete();
        wb_vld_i = 1'b1; wb_addr_i = 32'h3000;
        wb_data_i = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        fill_req_vld_i = 1'b1; fill_req_addr_i = 32'h3000;
        tick();
        wb_vld_i = 1'b0; fill_req_vld_i = 1'b0;
        n = 1;
        while (!fill_resp_vld_o && n < 300) begin tick(); n++; end
        chk("t3_latency", n, 10);
        chk("t3_data", fill_resp_data_o, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        for (int i = 0; i < 4; i++) chk_beat("t3_wr", i, 1'b1, 32'h3000 + 4*i, 32'hE0 + i);
        for (int i = 0; i < 4; i++) chk_beat("t3_rd", 4 + i, 1'b0, 32'h3000 + 4*i, 32'd0);
        tick();

        // Back-pressure: three stall cycles before every grant
        log_q.delete();
        gnt_wait = 3; stab_bad = 0;
        wb_vld_i = 1'b1; wb_addr_i = 32'h7000;
        wb_data_i = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        tick();
        wb_vld_i = 1'b0;
        n = 1;
        while (!wb_rdy_o && n < 300) begin tick(); n++; end
        chk("t4_rdy_cycle", n, 17);
        chk("t4_stable", stab_bad, 0);
        for (int i = 0; i < 4; i++) chk_beat("t4_beat", i, 1'b1, 32'h7000 + 4*i, 32'hF0 + i);
        gnt_wait = 0;
        tick();

        // Reset in RD_WAIT after two of four read beats returned
        rv_budget = 2; rv_count = 0;
        fill_req_vld_i = 1'b1; fill_req_addr_i = 32'h5000;
        tick();
        fill_req_vld_i = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t5_mid", {busy_o, mem_req_o, fill_resp_vld_o, rv_count[3:0]}, {3'b100, 4'd2});
        rst_n = 1'b0;
        rv_budget = -1;
        #1;
        chk("t5_rst_ctrl", {fill_req_rdy_o, wb_rdy_o, mem_req_o, mem_we_o, fill_resp_vld_o, busy_o}, 6'b110000);
        chk("t5_rst_addr", {mem_addr_o, fill_resp_data_o[63:0]}, 96'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        fill_req_vld_i = 1'b1; fill_req_addr_i = 32'h4000;
        tick();
        fill_req_vld_i = 1'b0;
        n = 1;
        while (!fill_resp_vld_o && n < 300) begin tick(); n++; end
        chk("t5_latency", n, 6);
        chk("t5_data", fill_resp_data_o, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        tick();
        chk("t5_idle", {busy_o, fill_resp_vld_o, fill_req_rdy_o}, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
